// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit for the MEM stage. Takes the EX-stage effective address,
// store data and funct3, runs a single valid/ready transaction on the data
// memory port, and returns sign/zero-extended load data for writeback.
// Misaligned accesses and illegal funct3 encodings retire without touching
// memory.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         EX request handshake (ready only in IDLE)
//   req_is_store, req_funct3    access kind (RV32I load/store funct3)
//   req_addr, req_wdata, req_rd effective address, rs2 data, load target
//   stall                       freezes IF/ID/EX while an access is pending
//   dm_req_valid/dm_req_ready   memory request handshake
//   dm_addr, dm_we, dm_wdata    word address, byte strobes, lane-replicated data
//   dm_rsp_valid, dm_rdata,
//   dm_rsp_err                  memory response (one pulse per request)
//   wb_valid, wb_rd, wb_data    load writeback pulse and held result
//   done                        one pulse per retired access
//   exc_misalign, exc_bus,
//   exc_addr                    exception pulses and held faulting address
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_we,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_rsp_valid,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_rsp_err,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              exc_misalign,
    output logic              exc_bus,
    output logic [ADDR_W-1:0] exc_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              is_store_p0;
    logic              mis_p0;
    logic              err_p0;
    logic [2:0]        funct3_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [4:0]        rd_p0;
    logic [3:0]        we_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic accept;
    logic rsp_take;
    logic req_bad;

    // Misaligned halfword/word or an encoding that is not an RV32I load/store.
    function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = off[0];
            3'b010:  bad = (off != 2'b00);
            3'b100:  bad = is_store;
            3'b101:  bad = is_store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] we;
        case (f3[1:0])
            2'b00:   we = 4'b0001 << off;
            2'b01:   we = 4'b0011 << off;
            default: we = 4'b1111;
        endcase
        return we;
    endfunction

    // Replicate the store datum across all lanes so the strobe alone selects bytes.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] d;
        case (f3[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                      input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0]        sh;
        logic signed [7:0]        sb;
        logic signed [15:0]       sh16;
        logic [DATA_W-1:0]        res;
        sh   = word >> {off, 3'b000};
        sb   = sh[7:0];
        sh16 = sh[15:0];
        case (f3)
            3'b000:  res = DATA_W'(sb);
            3'b001:  res = DATA_W'(sh16);
            3'b100:  res = DATA_W'(sh[7:0]);
            3'b101:  res = DATA_W'(sh[15:0]);
            default: res = sh;
        endcase
        return res;
    endfunction

    assign accept   = (state == S_IDLE) && req_valid;
    assign rsp_take = (state == S_WAIT) && dm_rsp_valid;
    assign req_bad  = access_bad(req_is_store, req_funct3, req_addr[1:0]);

    // Stage boundary: state register plus control and architected outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            is_store_p0 <= 1'b0;
            mis_p0      <= 1'b0;
            err_p0      <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            exc_addr    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_store_p0 <= req_is_store;
                mis_p0      <= req_bad;
                err_p0      <= 1'b0;
                if (req_bad) begin
                    exc_addr <= req_addr;
                end
            end
            if (rsp_take) begin
                err_p0 <= dm_rsp_err;
                if (dm_rsp_err) begin
                    exc_addr <= addr_p0;
                end else if (!is_store_p0) begin
                    wb_rd   <= rd_p0;
                    wb_data <= load_extend(funct3_p0, addr_p0[1:0], dm_rdata);
                end
            end
        end
    end

    // Stage boundary: accepted request fields, pre-aligned for the memory port
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr;
            rd_p0     <= req_rd;
            we_p0     <= req_is_store ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
            wdata_p0  <= store_lanes(req_funct3, req_wdata);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid)    state_nxt = req_bad ? S_RET : S_REQ;
            S_REQ:  if (dm_req_ready) state_nxt = S_WAIT;
            S_WAIT: if (dm_rsp_valid) state_nxt = S_RET;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // Stall is released in RET so the pipeline advances together with the
    // writeback/done pulse.
    always_comb begin
        req_ready    = 1'b0;
        stall        = 1'b0;
        dm_req_valid = 1'b0;
        dm_addr      = '0;
        dm_we        = 4'b0000;
        dm_wdata     = '0;
        wb_valid     = 1'b0;
        done         = 1'b0;
        exc_misalign = 1'b0;
        exc_bus      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
            end
            S_REQ: begin
                stall        = 1'b1;
                dm_req_valid = 1'b1;
                dm_addr      = {addr_p0[ADDR_W-1:2], 2'b00};
                dm_we        = we_p0;
                dm_wdata     = wdata_p0;
            end
            S_WAIT: begin
                stall = 1'b1;
            end
            default: begin
                done         = 1'b1;
                wb_valid     = !is_store_p0 && !mis_p0 && !err_p0;
                exc_misalign = mis_p0;
                exc_bus      = err_p0;
            end
        endcase
    end

endmodule
